// File: rtl/freq_counter_pkg.sv
// rtl/freq_counter_pkg.sv - shared state encoding and default sizing for the frequency counter
// Contents:
//   state_t        : window sequencer states (IDLE, COUNT, HOLD)
//   DFLT_PERIOD_W  : default gate period width in clk cycles
//   DFLT_COUNT_W   : default edge count / result width
//   DFLT_MAX_COUNT : default edge count saturation value
//   DFLT_PERIOD    : default gate period loaded at reset
package freq_counter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    HOLD  = 2'd2
  } state_t;

  localparam int DFLT_PERIOD_W  = 12;
  localparam int DFLT_COUNT_W   = 7;
  localparam int DFLT_MAX_COUNT = 99;
  localparam int DFLT_PERIOD    = 1000;

endpackage

// File: rtl/freq_edge_counter.sv
// rtl/freq_edge_counter.sv - saturating edge counter with clear and overflow accumulate
// Ports:
//   clk   : system clock
//   reset : synchronous active-high reset
//   clear : synchronous clear of count and overflow (wins over inc)
//   inc   : count one edge this cycle
//   cnt   : current count, never exceeds MAX_COUNT
//   ovf   : set when an edge arrives while cnt is already at MAX_COUNT
module freq_edge_counter
  import freq_counter_pkg::*;
#(
  parameter int COUNT_W   = DFLT_COUNT_W,
  parameter int MAX_COUNT = DFLT_MAX_COUNT
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clear,
  input  logic               inc,
  output logic [COUNT_W-1:0] cnt,
  output logic               ovf
);

  localparam logic [COUNT_W-1:0] MAX_VAL = COUNT_W'(MAX_COUNT);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      cnt <= '0;
      ovf <= 1'b0;
    end else if (inc) begin
      if (cnt < MAX_VAL) begin
        cnt <= cnt + COUNT_W'(1);
      end else begin
        ovf <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/freq_window_ctrl.sv
// rtl/freq_window_ctrl.sv - gate-window sequencer, period register and result latch of the frequency counter
// Ports:
//   clk             : system clock
//   reset           : synchronous active-high reset
//   period_in       : new gate period in clk cycles
//   period_load     : level; captures period_in every cycle while high and aborts the window
//   debug_mode      : level; freezes the measurement while high
//   signal_edge     : single-cycle pulse per rising edge of the measured signal
//   result          : edge count of the last completed window
//   result_overflow : last completed window saturated at MAX_COUNT
//   result_valid    : one-cycle pulse when result/result_overflow update
//   window_active   : high while in COUNT
//   period_q        : current period register
module freq_window_ctrl
  import freq_counter_pkg::*;
#(
  parameter int PERIOD_W       = DFLT_PERIOD_W,
  parameter int COUNT_W        = DFLT_COUNT_W,
  parameter int MAX_COUNT      = DFLT_MAX_COUNT,
  parameter int DEFAULT_PERIOD = DFLT_PERIOD
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [PERIOD_W-1:0] period_in,
  input  logic                period_load,
  input  logic                debug_mode,
  input  logic                signal_edge,
  output logic [COUNT_W-1:0]  result,
  output logic                result_overflow,
  output logic                result_valid,
  output logic                window_active,
  output logic [PERIOD_W-1:0] period_q
);

  localparam logic [COUNT_W-1:0] MAX_VAL = COUNT_W'(MAX_COUNT);

  state_t              state;
  logic [PERIOD_W-1:0] period_reg;
  logic [PERIOD_W-1:0] timer;
  logic [COUNT_W-1:0]  edge_cnt;
  logic                ovf_acc;

  logic               counting;
  logic               window_end;
  logic               at_max;
  logic [COUNT_W-1:0] close_cnt;
  logic               close_ovf;

  // Edges count only in COUNT and only when neither load nor debug overrides.
  assign counting   = (state == COUNT) && !period_load && !debug_mode;
  assign window_end = counting && (timer == '0);

  // The closing cycle's own edge belongs to the closing window, so the
  // latched result folds it in here while the counter itself is cleared.
  assign at_max    = (edge_cnt == MAX_VAL);
  assign close_cnt = (signal_edge && !at_max) ? edge_cnt + COUNT_W'(1) : edge_cnt;
  assign close_ovf = ovf_acc | (signal_edge & at_max);

  freq_edge_counter #(
    .COUNT_W   (COUNT_W),
    .MAX_COUNT (MAX_COUNT)
  ) u_edge_counter (
    .clk   (clk),
    .reset (reset),
    .clear ((state == IDLE) || window_end),
    .inc   (counting && signal_edge),
    .cnt   (edge_cnt),
    .ovf   (ovf_acc)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= IDLE;
      period_reg      <= PERIOD_W'(DEFAULT_PERIOD);
      timer           <= '0;
      result          <= '0;
      result_overflow <= 1'b0;
      result_valid    <= 1'b0;
      window_active   <= 1'b0;
    end else begin
      result_valid <= 1'b0;
      if (period_load) begin
        period_reg    <= period_in;
        state         <= IDLE;
        window_active <= 1'b0;
      end else if (debug_mode) begin
        state         <= HOLD;
        window_active <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            // A zero period parks the sequencer here; timer is never loaded
            // from it, so period_reg-1 cannot underflow.
            if (period_reg != '0) begin
              state         <= COUNT;
              timer         <= period_reg - PERIOD_W'(1);
              window_active <= 1'b1;
            end
          end
          COUNT: begin
            if (timer == '0) begin
              result          <= close_cnt;
              result_overflow <= close_ovf;
              result_valid    <= 1'b1;
              timer           <= period_reg - PERIOD_W'(1);
            end else begin
              timer <= timer - PERIOD_W'(1);
            end
          end
          HOLD: begin
            // Leaving debug discards the partial window via IDLE.
            state         <= IDLE;
            window_active <= 1'b0;
          end
          default: begin
            state         <= IDLE;
            window_active <= 1'b0;
          end
        endcase
      end
    end
  end

  assign period_q = period_reg;

endmodule
